// File: rtl/bench_pkg.sv
// ---------------------------------------------------------------------------
// bench_pkg
// Shared definitions for the benchmark run scheduler: FSM state encoding,
// condition count and indices, LED status patterns and small decode helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package bench_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACCUM = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam int NUM_COND = 4;

  localparam logic [1:0] COND_BASE2  = 2'd0;
  localparam logic [1:0] COND_BASE10 = 2'd1;
  localparam logic [1:0] COND_BASE12 = 2'd2;
  localparam logic [1:0] COND_ROUTER = 2'd3;

  localparam logic [3:0] LED_IDLE = 4'b0000;
  localparam logic [3:0] LED_ERR  = 4'b1111;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == ST_ISSUE) || (st == ST_WAIT) || (st == ST_ACCUM) || (st == ST_FINAL);
  endfunction

endpackage

// File: rtl/bench_argmax.sv
// ---------------------------------------------------------------------------
// bench_argmax
// Combinational 4-way selector: picks the condition with the most wins.
// Equal win counts are broken by the smaller minimum time, and a full tie
// goes to the lower index.
// Ports:
//   win_cnt  in  NUM_COND x CW  accumulated win counts
//   t_min    in  NUM_COND x TW  minimum observed times
//   sel      out 2              winning condition index
// ---------------------------------------------------------------------------
module bench_argmax
  import bench_pkg::*;
#(
  parameter int CW = 8,
  parameter int TW = 32
) (
  input  logic [NUM_COND-1:0][CW-1:0] win_cnt,
  input  logic [NUM_COND-1:0][TW-1:0] t_min,
  output logic [1:0]                  sel
);

  logic [1:0] best;

  // Scanning upward with strict comparisons leaves full ties on the lower index.
  always_comb begin
    best = COND_BASE2;
    for (int i = 1; i < NUM_COND; i++) begin
      if ((win_cnt[i] > win_cnt[best]) ||
          ((win_cnt[i] == win_cnt[best]) && (t_min[i] < t_min[best]))) begin
        best = 2'(i);
      end
    end
    sel = best;
  end

endmodule

// File: rtl/bench_run_scheduler.sv
// ---------------------------------------------------------------------------
// bench_run_scheduler
// Issues NUM_RUNS back-to-back starts to the bench engine per accepted
// request, guards each run with a timeout, accumulates per-condition win
// counts and minimum times, and reports an overall winner.
// Ports:
//   sysclk, rst                 clock, synchronous active-high reset
//   req_start, req_abort        one-cycle start / abort requests
//   eng_start                   one-cycle start pulse to the engine
//   eng_done, eng_winner,
//   eng_t0..eng_t3              engine completion pulse and its results
//   busy, run_idx               activity flag, current run index
//   win_cnt0..3, t_min0..3      accumulated statistics
//   best_winner, result_valid   final result and its qualifier
//   timeout_err                 sticky timeout flag
//   led_onehot                  status display
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a start request
// ISSUE    | engine start pulse for the current run
// WAIT     | waiting for engine completion, timeout counter running
// ACCUM    | fold captured run results into counts and minima
// FINAL    | register the overall winner
// DONE     | results valid and held
// ERROR    | a run timed out; results held
// ---------------------------------------------------------------------------
module bench_run_scheduler
  import bench_pkg::*;
#(
  parameter int NUM_RUNS       = 8,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TW             = 32,
  parameter int CW             = 8
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          req_start,
  input  logic          req_abort,
  output logic          eng_start,
  input  logic          eng_done,
  input  logic [1:0]    eng_winner,
  input  logic [TW-1:0] eng_t0,
  input  logic [TW-1:0] eng_t1,
  input  logic [TW-1:0] eng_t2,
  input  logic [TW-1:0] eng_t3,
  output logic          busy,
  output logic [7:0]    run_idx,
  output logic [CW-1:0] win_cnt0,
  output logic [CW-1:0] win_cnt1,
  output logic [CW-1:0] win_cnt2,
  output logic [CW-1:0] win_cnt3,
  output logic [TW-1:0] t_min0,
  output logic [TW-1:0] t_min1,
  output logic [TW-1:0] t_min2,
  output logic [TW-1:0] t_min3,
  output logic [1:0]    best_winner,
  output logic          result_valid,
  output logic          timeout_err,
  output logic [3:0]    led_onehot
);

  localparam int              WCW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      RUN_LAST  = 8'(NUM_RUNS - 1);

  logic [2:0]                  state_q, state_d;
  logic [WCW-1:0]              wait_cnt_q;
  logic [1:0]                  cap_winner_q;
  logic [NUM_COND-1:0][TW-1:0] cap_t_q;
  logic [NUM_COND-1:0][CW-1:0] win_cnt_q;
  logic [NUM_COND-1:0][TW-1:0] t_min_q;
  logic [7:0]                  run_idx_q;
  logic [1:0]                  best_winner_q;
  logic                        timeout_err_q;
  logic [1:0]                  argmax_sel;

  logic busy_st;
  logic start_ok;
  logic abort_now;
  logic last_run;
  logic timeout_hit;

  assign busy_st     = state_is_busy(state_q);
  assign start_ok    = req_start && !busy_st;
  assign abort_now   = req_abort && busy_st;
  assign last_run    = (run_idx_q == RUN_LAST);
  assign timeout_hit = (wait_cnt_q == WAIT_LAST);

  bench_argmax #(
    .CW (CW),
    .TW (TW)
  ) u_argmax (
    .win_cnt (win_cnt_q),
    .t_min   (t_min_q),
    .sel     (argmax_sel)
  );

  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: if (req_start) state_d = ST_ISSUE;
        ST_ISSUE:                   state_d = ST_WAIT;
        // A completion on the last permitted cycle still counts as a result.
        ST_WAIT: begin
          if (eng_done)         state_d = ST_ACCUM;
          else if (timeout_hit) state_d = ST_ERROR;
        end
        ST_ACCUM:                   state_d = last_run ? ST_FINAL : ST_ISSUE;
        ST_FINAL:                   state_d = ST_DONE;
        default:                    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      cap_winner_q  <= '0;
      cap_t_q       <= '0;
      win_cnt_q     <= '0;
      t_min_q       <= '1;
      run_idx_q     <= '0;
      best_winner_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        win_cnt_q     <= '0;
        t_min_q       <= '1;
        run_idx_q     <= '0;
        timeout_err_q <= 1'b0;
      end

      // An abort freezes every statistic where it stands.
      if (!abort_now) begin
        case (state_q)
          ST_ISSUE: wait_cnt_q <= '0;
          ST_WAIT: begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
            if (eng_done) begin
              cap_winner_q <= eng_winner;
              cap_t_q      <= {eng_t3, eng_t2, eng_t1, eng_t0};
            end else if (timeout_hit) begin
              timeout_err_q <= 1'b1;
            end
          end
          ST_ACCUM: begin
            if (win_cnt_q[cap_winner_q] != {CW{1'b1}}) begin
              win_cnt_q[cap_winner_q] <= win_cnt_q[cap_winner_q] + 1'b1;
            end
            for (int i = 0; i < NUM_COND; i++) begin
              if (cap_t_q[i] < t_min_q[i]) t_min_q[i] <= cap_t_q[i];
            end
            if (!last_run) run_idx_q <= run_idx_q + 8'd1;
          end
          ST_FINAL: best_winner_q <= argmax_sel;
          default: ;
        endcase
      end
    end
  end

  // Status outputs are pure decodes of registered state.
  always_comb begin
    case (state_q)
      ST_ISSUE, ST_WAIT, ST_ACCUM, ST_FINAL: led_onehot = onehot4(run_idx_q[1:0]);
      ST_DONE:                               led_onehot = onehot4(best_winner_q);
      ST_ERROR:                              led_onehot = LED_ERR;
      default:                               led_onehot = LED_IDLE;
    endcase
  end

  assign eng_start    = (state_q == ST_ISSUE);
  assign busy         = busy_st;
  assign result_valid = (state_q == ST_DONE);
  assign run_idx      = run_idx_q;
  assign win_cnt0     = win_cnt_q[COND_BASE2];
  assign win_cnt1     = win_cnt_q[COND_BASE10];
  assign win_cnt2     = win_cnt_q[COND_BASE12];
  assign win_cnt3     = win_cnt_q[COND_ROUTER];
  assign t_min0       = t_min_q[COND_BASE2];
  assign t_min1       = t_min_q[COND_BASE10];
  assign t_min2       = t_min_q[COND_BASE12];
  assign t_min3       = t_min_q[COND_ROUTER];
  assign best_winner  = best_winner_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_bench_run_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bench_run_scheduler
// Self-checking bench for bench_run_scheduler with NUM_RUNS=6,
// TIMEOUT_CYCLES=64, CW=2 (so win counters saturate at 3).
// ---------------------------------------------------------------------------
module tb_bench_run_scheduler;

  localparam int NR = 6;
  localparam int TO = 64;
  localparam int TW = 32;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          req_start = 1'b0;
  logic          req_abort = 1'b0;
  logic          eng_start;
  logic          eng_done = 1'b0;
  logic [1:0]    eng_winner = 2'd0;
  logic [TW-1:0] eng_t0 = '0, eng_t1 = '0, eng_t2 = '0, eng_t3 = '0;
  logic          busy;
  logic [7:0]    run_idx;
  logic [CW-1:0] win_cnt0, win_cnt1, win_cnt2, win_cnt3;
  logic [TW-1:0] t_min0, t_min1, t_min2, t_min3;
  logic [1:0]    best_winner;
  logic          result_valid;
  logic          timeout_err;
  logic [3:0]    led_onehot;

  bench_run_scheduler #(
    .NUM_RUNS       (NR),
    .TIMEOUT_CYCLES (TO),
    .TW             (TW),
    .CW             (CW)
  ) dut (
    .sysclk       (sysclk),
    .rst          (rst),
    .req_start    (req_start),
    .req_abort    (req_abort),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .eng_winner   (eng_winner),
    .eng_t0       (eng_t0),
    .eng_t1       (eng_t1),
    .eng_t2       (eng_t2),
    .eng_t3       (eng_t3),
    .busy         (busy),
    .run_idx      (run_idx),
    .win_cnt0     (win_cnt0),
    .win_cnt1     (win_cnt1),
    .win_cnt2     (win_cnt2),
    .win_cnt3     (win_cnt3),
    .t_min0       (t_min0),
    .t_min1       (t_min1),
    .t_min2       (t_min2),
    .t_min3       (t_min3),
    .best_winner  (best_winner),
    .result_valid (result_valid),
    .timeout_err  (timeout_err),
    .led_onehot   (led_onehot)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  int n_pulses = 0;
  always @(posedge sysclk) cyc <= cyc + 1;
  always @(negedge sysclk) if (eng_start === 1'b1) n_pulses <= n_pulses + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Per-run engine behaviour and the reference model's results.
  int            lat_tab[NR];
  logic [1:0]    win_tab[NR];
  logic [TW-1:0] t_tab[NR][4];
  int            start_cyc[NR];
  logic [CW-1:0] exp_cnt[4];
  logic [TW-1:0] exp_tmin[4];
  logic [1:0]    exp_best;

  // Reference: count wins per condition, clip at the counter maximum, take
  // per-condition minima, then rank by (most wins, smallest time, lowest index).
  task automatic model_compute(input int n);
    int raw[4];
    int mx;
    logic [TW-1:0] mt;
    for (int c = 0; c < 4; c++) begin
      raw[c] = 0;
      exp_tmin[c] = '1;
    end
    for (int r = 0; r < n; r++) begin
      raw[win_tab[r]] += 1;
      for (int c = 0; c < 4; c++)
        if (t_tab[r][c] < exp_tmin[c]) exp_tmin[c] = t_tab[r][c];
    end
    mx = 0;
    for (int c = 0; c < 4; c++) begin
      exp_cnt[c] = CW'((raw[c] > CMAX) ? CMAX : raw[c]);
      if (int'(exp_cnt[c]) > mx) mx = int'(exp_cnt[c]);
    end
    mt = '1;
    for (int c = 0; c < 4; c++)
      if (int'(exp_cnt[c]) == mx && exp_tmin[c] < mt) mt = exp_tmin[c];
    exp_best = 2'd0;
    for (int c = 3; c >= 0; c--)
      if (int'(exp_cnt[c]) == mx && exp_tmin[c] == mt) exp_best = 2'(c);
  endtask

  task automatic pulse_start();
    req_start = 1'b1;
    @(negedge sysclk);
    req_start = 1'b0;
  endtask

  task automatic wait_start(output int c);
    c = -1;
    for (int n = 0; n < 200; n++) begin
      if (eng_start === 1'b1) begin
        c = cyc;
        return;
      end
      @(negedge sysclk);
    end
  endtask

  // Plays the engine for n runs using the tables; optionally pokes req_start
  // while run 2 is in flight. Returns at the negedge after the last eng_done.
  task automatic serve_all(input int n, input bit poke, output int served);
    int c;
    served = 0;
    for (int k = 0; k < n; k++) begin
      wait_start(c);
      if (c < 0) return;
      start_cyc[k] = c;
      for (int i = 0; i < lat_tab[k]; i++) begin
        @(negedge sysclk);
        req_start = poke && (k == 2) && (i == 0);
      end
      eng_done   = 1'b1;
      eng_winner = win_tab[k];
      eng_t0 = t_tab[k][0]; eng_t1 = t_tab[k][1];
      eng_t2 = t_tab[k][2]; eng_t3 = t_tab[k][3];
      @(negedge sysclk);
      eng_done = 1'b0;
      req_start = 1'b0;
      eng_winner = 2'($urandom);
      eng_t0 = $urandom; eng_t1 = $urandom; eng_t2 = $urandom; eng_t3 = $urandom;
      served++;
    end
  endtask

  task automatic fill_random(input int max_lat);
    for (int r = 0; r < NR; r++) begin
      lat_tab[r] = $urandom_range(1, max_lat);
      win_tab[r] = 2'($urandom_range(0, 3));
      for (int c = 0; c < 4; c++) t_tab[r][c] = TW'($urandom_range(1, 6));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    @(negedge sysclk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (eng_start !== 1'b0) $display("FAIL reset_eng_start got %b want 0", eng_start); else n_pass++;
    n_checks++; if (run_idx !== 8'd0) $display("FAIL reset_run_idx got %0d want 0", run_idx); else n_pass++;
    n_checks++; if ({win_cnt3, win_cnt2, win_cnt1, win_cnt0} !== '0)
      $display("FAIL reset_win_cnt got %h want 0", {win_cnt3, win_cnt2, win_cnt1, win_cnt0}); else n_pass++;
    n_checks++; if ({t_min3, t_min2, t_min1, t_min0} !== {4*TW{1'b1}})
      $display("FAIL reset_t_min got %h want all ones", {t_min3, t_min2, t_min1, t_min0}); else n_pass++;
    n_checks++; if (best_winner !== 2'd0) $display("FAIL reset_best got %0d want 0", best_winner); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", result_valid); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (led_onehot !== 4'b0000) $display("FAIL reset_led got %b want 0000", led_onehot); else n_pass++;
  endtask

  // Check DONE-state results against the model after serve_all returns.
  task automatic check_done(input string tag);
    logic [3:0] exp_led;
    n_checks++; if (busy !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL %s_accum busy=%b valid=%b want 1/0", tag, busy, result_valid); else n_pass++;
    @(negedge sysclk);
    n_checks++; if (result_valid !== 1'b0)
      $display("FAIL %s_final valid=%b want 0", tag, result_valid); else n_pass++;
    @(negedge sysclk);
    n_checks++; if (result_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done valid=%b busy=%b want 1/0", tag, result_valid, busy); else n_pass++;
    model_compute(NR);
    exp_led = 4'b0001 << exp_best;
    n_checks++; if ({win_cnt3, win_cnt2, win_cnt1, win_cnt0} !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]})
      $display("FAIL %s_win_cnt got %h want %h", tag, {win_cnt3, win_cnt2, win_cnt1, win_cnt0},
               {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}); else n_pass++;
    n_checks++; if ({t_min3, t_min2, t_min1, t_min0} !== {exp_tmin[3], exp_tmin[2], exp_tmin[1], exp_tmin[0]})
      $display("FAIL %s_t_min got %h want %h", tag, {t_min3, t_min2, t_min1, t_min0},
               {exp_tmin[3], exp_tmin[2], exp_tmin[1], exp_tmin[0]}); else n_pass++;
    n_checks++; if (best_winner !== exp_best)
      $display("FAIL %s_best got %0d want %0d", tag, best_winner, exp_best); else n_pass++;
    n_checks++; if (led_onehot !== exp_led)
      $display("FAIL %s_led got %b want %b", tag, led_onehot, exp_led); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0)
      $display("FAIL %s_timeout got %b want 0", tag, timeout_err); else n_pass++;
  endtask

  task automatic test_fixed_winner();
    int served, p0;
    for (int r = 0; r < NR; r++) begin
      lat_tab[r] = 40; win_tab[r] = 2'd3;
      t_tab[r][0] = 400; t_tab[r][1] = 300; t_tab[r][2] = 200; t_tab[r][3] = 100;
    end
    p0 = n_pulses;
    pulse_start();
    serve_all(NR, 1'b1, served);
    n_checks++; if (served !== NR) $display("FAIL fixed_served got %0d want %0d", served, NR); else n_pass++;
    for (int k = 1; k < NR; k++) begin
      n_checks++; if (start_cyc[k] - start_cyc[k-1] !== 42)
        $display("FAIL fixed_spacing%0d got %0d want 42", k, start_cyc[k] - start_cyc[k-1]); else n_pass++;
    end
    check_done("fixed");
    n_checks++; if (win_cnt3 !== 2'd3) $display("FAIL fixed_saturate got %0d want 3", win_cnt3); else n_pass++;
    n_checks++; if (n_pulses - p0 !== NR)
      $display("FAIL fixed_pulses got %0d want %0d", n_pulses - p0, NR); else n_pass++;
    req_abort = 1'b1;
    @(negedge sysclk);
    req_abort = 1'b0;
    @(negedge sysclk);
    n_checks++; if (result_valid !== 1'b1 || led_onehot !== 4'b1000)
      $display("FAIL abort_in_done valid=%b led=%b want 1/1000", result_valid, led_onehot); else n_pass++;
  endtask

  task automatic test_tie();
    int served;
    for (int r = 0; r < NR; r++) begin
      lat_tab[r] = $urandom_range(1, 10);
      for (int c = 0; c < 4; c++) t_tab[r][c] = 90;
    end
    win_tab[0] = 1; win_tab[1] = 2; win_tab[2] = 1; win_tab[3] = 2; win_tab[4] = 0; win_tab[5] = 3;
    t_tab[0][1] = 50; t_tab[1][2] = 40;
    pulse_start();
    serve_all(NR, 1'b0, served);
    n_checks++; if (served !== NR) $display("FAIL tie_served got %0d want %0d", served, NR); else n_pass++;
    check_done("tie");
    n_checks++; if (best_winner !== 2'd2) $display("FAIL tie_best got %0d want 2", best_winner); else n_pass++;
  endtask

  task automatic test_random(input int iters, input bit at_limit);
    int served;
    for (int it = 0; it < iters; it++) begin
      fill_random(24);
      if (at_limit) for (int r = 0; r < NR; r++) lat_tab[r] = TO;
      pulse_start();
      serve_all(NR, 1'b0, served);
      n_checks++; if (served !== NR)
        $display("FAIL rand%0d_served got %0d want %0d", it, served, NR); else n_pass++;
      check_done(at_limit ? "limit" : "rand");
    end
  endtask

  task automatic test_timeout();
    int s, early;
    pulse_start();
    wait_start(s);
    n_checks++; if (s < 0) $display("FAIL to_start got none want eng_start"); else n_pass++;
    early = 0;
    repeat (TO) begin
      @(negedge sysclk);
      if (busy !== 1'b1 || timeout_err !== 1'b0) early++;
    end
    n_checks++; if (early !== 0) $display("FAIL to_early got %0d bad cycles want 0", early); else n_pass++;
    @(negedge sysclk);
    n_checks++; if (timeout_err !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL to_error err=%b busy=%b valid=%b want 1/0/0", timeout_err, busy, result_valid); else n_pass++;
    n_checks++; if (led_onehot !== 4'b1111) $display("FAIL to_led got %b want 1111", led_onehot); else n_pass++;
    repeat (3) @(negedge sysclk);
    n_checks++; if (led_onehot !== 4'b1111 || timeout_err !== 1'b1)
      $display("FAIL to_hold led=%b err=%b want 1111/1", led_onehot, timeout_err); else n_pass++;
    pulse_start();
    n_checks++; if (timeout_err !== 1'b0 || eng_start !== 1'b1 || busy !== 1'b1)
      $display("FAIL to_restart err=%b start=%b busy=%b want 0/1/1", timeout_err, eng_start, busy); else n_pass++;
    req_abort = 1'b1;
    @(negedge sysclk);
    req_abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || led_onehot !== 4'b0000)
      $display("FAIL to_abort busy=%b led=%b want 0/0000", busy, led_onehot); else n_pass++;
  endtask

  task automatic test_abort();
    int served, s, p0;
    logic [4*CW-1:0] cnt_before;
    fill_random(12);
    pulse_start();
    serve_all(2, 1'b0, served);
    wait_start(s);
    n_checks++; if (served !== 2 || s < 0)
      $display("FAIL abort_setup served=%0d start=%0d want 2/>=0", served, s); else n_pass++;
    @(negedge sysclk);
    req_abort = 1'b1;
    @(negedge sysclk);
    req_abort = 1'b0;
    model_compute(2);
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || led_onehot !== 4'b0000)
      $display("FAIL abort_idle busy=%b valid=%b led=%b want 0/0/0000", busy, result_valid, led_onehot); else n_pass++;
    n_checks++; if (run_idx !== 8'd2) $display("FAIL abort_run_idx got %0d want 2", run_idx); else n_pass++;
    n_checks++; if ({win_cnt3, win_cnt2, win_cnt1, win_cnt0} !== {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]})
      $display("FAIL abort_retained got %h want %h", {win_cnt3, win_cnt2, win_cnt1, win_cnt0},
               {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]}); else n_pass++;
    cnt_before = {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
    p0 = n_pulses;
    repeat (3) @(negedge sysclk);
    eng_done = 1'b1; eng_winner = 2'd0; eng_t0 = 1; eng_t1 = 1; eng_t2 = 1; eng_t3 = 1;
    @(negedge sysclk);
    eng_done = 1'b0;
    repeat (3) @(negedge sysclk);
    n_checks++; if ({win_cnt3, win_cnt2, win_cnt1, win_cnt0} !== cnt_before || busy !== 1'b0)
      $display("FAIL abort_stray_done got %h busy=%b want %h/0", {win_cnt3, win_cnt2, win_cnt1, win_cnt0},
               busy, cnt_before); else n_pass++;
    n_checks++; if (n_pulses !== p0) $display("FAIL abort_no_start got %0d want %0d", n_pulses, p0); else n_pass++;
  endtask

  task automatic test_rst_in_wait();
    int served, s;
    fill_random(12);
    pulse_start();
    serve_all(2, 1'b0, served);
    wait_start(s);
    n_checks++; if (served !== 2 || s < 0)
      $display("FAIL rstw_setup served=%0d start=%0d want 2/>=0", served, s); else n_pass++;
    @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    n_checks++; if ({busy, eng_start, result_valid, timeout_err} !== 4'b0000 || run_idx !== 8'd0)
      $display("FAIL rstw_ctrl flags=%b run_idx=%0d want 0000/0", {busy, eng_start, result_valid, timeout_err},
               run_idx); else n_pass++;
    n_checks++; if ({win_cnt3, win_cnt2, win_cnt1, win_cnt0} !== '0 || best_winner !== 2'd0 || led_onehot !== 4'b0000)
      $display("FAIL rstw_stats cnt=%h best=%0d led=%b want 0/0/0000", {win_cnt3, win_cnt2, win_cnt1, win_cnt0},
               best_winner, led_onehot); else n_pass++;
    n_checks++; if ({t_min3, t_min2, t_min1, t_min0} !== {4*TW{1'b1}})
      $display("FAIL rstw_t_min got %h want all ones", {t_min3, t_min2, t_min1, t_min0}); else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge sysclk);
    test_reset();
    test_fixed_winner();
    test_tie();
    test_random(4, 1'b0);
    test_random(1, 1'b1);
    test_timeout();
    test_abort();
    test_rst_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
